// File: rtl/sram_responder.sv
// Chip-side responder for an async-SRAM pin bus: byte-lane writes, registered reads on DQ. Optional macro: SRAM_RESP_PROTOCOL_CHECK_EN.
// Latency: a write commits on its edge; read data drives DQ after READ_LATENCY consecutive stable read edges.
// Backpressure: none; DQ is released combinationally when the read condition or the address goes away.
module sram_responder #(
    parameter int ADDR_W       = 18,
    parameter int DATA_W       = 16,
    parameter int DEPTH        = 65536,
    parameter int READ_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [DATA_W-1:0] SRAM_DQ,
    input  logic              SRAM_CE_N,
    input  logic              SRAM_WE_N,
    input  logic              SRAM_OE_N,
    input  logic              SRAM_UB_N,
    input  logic              SRAM_LB_N,
    output logic              protocol_err
);

    localparam int         IDX_W = $clog2(DEPTH);
    localparam int         HALF  = DATA_W / 2;
    localparam logic [2:0] LAT_C = 3'(READ_LATENCY);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_VALID
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   lat_addr_q, lat_addr_d;
    logic [DATA_W-1:0]   rdata_q;
    logic                load_rdata;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                write_cond;
    logic                read_cond;
    logic                addr_match;
    logic                drive;
    logic [1:0]          dq_oe;      // [1] upper lane, [0] lower lane
    logic [IDX_W-1:0]    idx;

    assign write_cond = !SRAM_CE_N && !SRAM_WE_N;
    assign read_cond  = !SRAM_CE_N &&  SRAM_WE_N && !SRAM_OE_N;
    assign addr_match = (SRAM_ADDR == lat_addr_q);
    assign idx        = SRAM_ADDR[IDX_W-1:0];

    // Lanes drive only while the read that produced rdata is still being asserted.
    assign drive = (state_q == S_VALID) && read_cond && addr_match;
    assign dq_oe = {drive && !SRAM_UB_N, drive && !SRAM_LB_N};

    assign SRAM_DQ[DATA_W-1:HALF] = dq_oe[1] ? rdata_q[DATA_W-1:HALF] : {HALF{1'bz}};
    assign SRAM_DQ[HALF-1:0]      = dq_oe[0] ? rdata_q[HALF-1:0]      : {HALF{1'bz}};

    // Read-access sequencing: restart on new address, count stable edges, hold in VALID.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lat_addr_d = lat_addr_q;
        load_rdata = 1'b0;
        if (write_cond) begin
            state_d = S_IDLE;
            cnt_d   = 3'd0;
        end else if (read_cond) begin
            if (state_q == S_IDLE || !addr_match) begin
                lat_addr_d = SRAM_ADDR;
                cnt_d      = 3'd1;
                if (READ_LATENCY == 1) begin
                    load_rdata = 1'b1;
                    state_d    = S_VALID;
                end else begin
                    state_d    = S_ACCESS;
                end
            end else if (state_q == S_ACCESS) begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q + 3'd1 == LAT_C) begin
                    load_rdata = 1'b1;
                    state_d    = S_VALID;
                end
            end
        end else begin
            state_d = S_IDLE;
            cnt_d   = 3'd0;
        end
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 3'd0;
            lat_addr_q <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lat_addr_q <= lat_addr_d;
            if (load_rdata) begin
                rdata_q <= mem[idx];
            end
        end
    end

    // Storage array: not reset; reset only blocks a write on its edge.
    always_ff @(posedge clk) begin
        if (rst && write_cond) begin
            if (!SRAM_UB_N) begin
                mem[idx][DATA_W-1:HALF] <= SRAM_DQ[DATA_W-1:HALF];
            end
            if (!SRAM_LB_N) begin
                mem[idx][HALF-1:0] <= SRAM_DQ[HALF-1:0];
            end
        end
    end

`ifdef SRAM_RESP_PROTOCOL_CHECK_EN
    logic perr_q;

    // Sticky flag: WE and OE both low, or no byte lane enabled on an access.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perr_q <= 1'b0;
        end else if (!SRAM_CE_N && ((!SRAM_WE_N && !SRAM_OE_N) ||
                                    (SRAM_UB_N && SRAM_LB_N && (write_cond || read_cond)))) begin
            perr_q <= 1'b1;
        end
    end

    assign protocol_err = perr_q;
`else
    assign protocol_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Randomized + directed bench for sram_responder with a queue scoreboard against a run-length read model.
// Latency: expectations are pushed per cycle and popped by a negedge monitor in the same cycle.
// Backpressure: none; the bench owns DQ only while WE_N is low.
module tb_sram_responder;

    localparam int ADDR_W = 18;
    localparam int DEPTH  = 65536;
    localparam int LAT    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce_n, we_n, oe_n, ub_n, lb_n;
    logic [17:0] addr;
    logic        tb_drv;
    logic [15:0] tb_dat;
    wire  [15:0] dq;
    logic        perr;

    assign dq = tb_drv ? tb_dat : 16'bz;

    always #5 clk = ~clk;

    sram_responder #(
        .ADDR_W(ADDR_W), .DATA_W(16), .DEPTH(DEPTH), .READ_LATENCY(LAT)
    ) dut (
        .clk(clk), .rst(rst), .SRAM_ADDR(addr), .SRAM_DQ(dq),
        .SRAM_CE_N(ce_n), .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n),
        .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .protocol_err(perr)
    );

`ifdef SRAM_RESP_PROTOCOL_CHECK_EN
    localparam bit PCHK = 1'b1;
`else
    localparam bit PCHK = 1'b0;
`endif

    typedef struct {
        logic [1:0]  oe;
        logic [15:0] dat;
        logic [1:0]  known;
        logic        perr;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   passes = 0;

    // Reference model: memory as sparse arrays, reads as a count of stable read edges.
    logic [15:0] mem_m [int];
    logic [1:0]  kn_m  [int];
    int          run;
    logic [17:0] run_addr;
    logic [15:0] cap;
    logic [1:0]  capk;
    bit          perr_m;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    endfunction

    function automatic void model_edge();
        int  idx;
        bit  wr, rd;
        idx = int'(addr) % DEPTH;
        wr  = !ce_n && !we_n;
        rd  = !ce_n && we_n && !oe_n;
        if (!rst) begin
            run = 0; run_addr = '0; perr_m = 1'b0;
            return;
        end
        if (PCHK && !ce_n && ((!we_n && !oe_n) || (ub_n && lb_n && (wr || rd)))) perr_m = 1'b1;
        if (wr) begin
            if (!mem_m.exists(idx)) begin mem_m[idx] = 16'h0; kn_m[idx] = 2'b00; end
            if (!ub_n) begin mem_m[idx][15:8] = tb_dat[15:8]; kn_m[idx][1] = 1'b1; end
            if (!lb_n) begin mem_m[idx][7:0]  = tb_dat[7:0];  kn_m[idx][0] = 1'b1; end
            run = 0;
        end else if (rd) begin
            if (run > 0 && addr == run_addr) begin
                if (run < LAT) run++;
            end else begin
                run = 1; run_addr = addr;
            end
            if (run == LAT) begin
                if (mem_m.exists(idx)) begin cap = mem_m[idx]; capk = kn_m[idx]; end
                else begin cap = 16'h0; capk = 2'b00; end
            end
        end else begin
            run = 0;
        end
    endfunction

    task automatic drive(input bit r, input bit c, input bit w, input bit o, input bit u,
                         input bit l, input logic [17:0] a, input logic [15:0] d);
        exp_t e;
        rst = r; ce_n = c; we_n = w; oe_n = o; ub_n = u; lb_n = l; addr = a;
        tb_drv = !w; tb_dat = d;
        e.oe = 2'b00;
        if (!c && w && !o && run == LAT && a == run_addr) e.oe = {!u, !l};
        e.dat = cap; e.known = capk; e.perr = perr_m;
        sbq.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic cyc(input bit r, input bit c, input bit w, input bit o, input bit u,
                       input bit l, input logic [17:0] a, input logic [15:0] d);
        drive(r, c, w, o, u, l, a, d);
        tick();
    endtask

    // Constant-valued spot check of the bus inside the current cycle.
    task automatic expect_dq(input string nm, input logic [1:0] woe, input logic [15:0] wdat);
        logic [15:0] m;
        #3;
        chk({nm, "_oe"}, 32'(dut.dq_oe), 32'(woe));
        m = {{8{woe[1]}}, {8{woe[0]}}};
        if (woe != 2'b00) chk({nm, "_dat"}, 32'(dq & m), 32'(wdat & m));
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle.
    initial begin
        exp_t e;
        logic [15:0] m;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("sb_oe", 32'(dut.dq_oe), 32'(e.oe));
                chk("sb_perr", 32'(perr), 32'(e.perr));
                m = {{8{e.oe[1] & e.known[1]}}, {8{e.oe[0] & e.known[0]}}};
                if (m != 16'h0) chk("sb_dat", 32'(dq & m), 32'(e.dat & m));
            end
        end
    end

    initial begin
        logic [17:0] pool [6];
        bit  c, w, o, u, l;
        logic [17:0] a;
        pool[0] = 18'd5; pool[1] = 18'd9; pool[2] = 18'd3;
        pool[3] = 18'(DEPTH + 3); pool[4] = 18'd1; pool[5] = 18'h2ABCD;
        run = 0; run_addr = '0; cap = '0; capk = '0; perr_m = 1'b0;

        // Reset held for two edges before the model starts tracking.
        rst = 1'b0; ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1; ub_n = 1'b0; lb_n = 1'b0;
        addr = '0; tb_drv = 1'b0; tb_dat = '0;
        repeat (2) @(posedge clk);
        model_edge();
        #1;

        // Idle after reset.
        drive(1, 1, 1, 1, 0, 0, 18'd0, 16'h0);
        expect_dq("idle_z", 2'b00, 16'h0);
        chk("idle_perr", 32'(perr), 32'd0);
        tick();

        // Full write then read with latency 2.
        cyc(1, 0, 0, 1, 0, 0, 18'd5, 16'hBEEF);
        drive(1, 0, 1, 0, 0, 0, 18'd5, 16'h0); expect_dq("rd5_e0", 2'b00, 16'h0);   tick();
        drive(1, 0, 1, 0, 0, 0, 18'd5, 16'h0); expect_dq("rd5_e1", 2'b00, 16'h0);   tick();
        drive(1, 0, 1, 0, 0, 0, 18'd5, 16'h0); expect_dq("rd5_e2", 2'b11, 16'hBEEF); tick();
        drive(1, 0, 1, 0, 0, 0, 18'd5, 16'h0); expect_dq("rd5_hold", 2'b11, 16'hBEEF); tick();
        drive(1, 0, 1, 1, 0, 0, 18'd5, 16'h0); expect_dq("oe_release", 2'b00, 16'h0); tick();

        // Byte lanes.
        cyc(1, 0, 0, 1, 0, 0, 18'd9, 16'h1234);
        cyc(1, 0, 0, 1, 0, 1, 18'd9, 16'hAB00);
        cyc(1, 0, 1, 0, 0, 0, 18'd9, 16'h0);
        cyc(1, 0, 1, 0, 0, 0, 18'd9, 16'h0);
        drive(1, 0, 1, 0, 0, 0, 18'd9, 16'h0); expect_dq("lane_merge", 2'b11, 16'hAB34); tick();
        drive(1, 0, 1, 0, 1, 0, 18'd9, 16'h0); expect_dq("lane_lb_only", 2'b01, 16'h0034); tick();
        cyc(1, 1, 1, 1, 0, 0, 18'd0, 16'h0);

        // Address switch in ACCESS restarts the latency count.
        cyc(1, 0, 1, 0, 0, 0, 18'd5, 16'h0);
        drive(1, 0, 1, 0, 0, 0, 18'd9, 16'h0); expect_dq("sw_e0", 2'b00, 16'h0); tick();
        drive(1, 0, 1, 0, 0, 0, 18'd9, 16'h0); expect_dq("sw_e1", 2'b00, 16'h0); tick();
        drive(1, 0, 1, 0, 0, 0, 18'd9, 16'h0); expect_dq("sw_e2", 2'b11, 16'hAB34); tick();
        drive(1, 0, 1, 0, 0, 0, 18'd5, 16'h0); expect_dq("sw_valid_rel", 2'b00, 16'h0); tick();
        cyc(1, 1, 1, 1, 0, 0, 18'd0, 16'h0);

        // Address wrap and reset abort.
        cyc(1, 0, 0, 1, 0, 0, 18'(DEPTH + 3), 16'h0F0F);
        cyc(1, 0, 1, 0, 0, 0, 18'd3, 16'h0);
        cyc(1, 0, 1, 0, 0, 0, 18'd3, 16'h0);
        drive(1, 0, 1, 0, 0, 0, 18'd3, 16'h0); expect_dq("wrap", 2'b11, 16'h0F0F); tick();
        cyc(1, 1, 1, 1, 0, 0, 18'd0, 16'h0);
        cyc(1, 0, 1, 0, 0, 0, 18'd3, 16'h0);
        cyc(0, 0, 1, 0, 0, 0, 18'd3, 16'h0);
        drive(1, 0, 1, 0, 0, 0, 18'd3, 16'h0); expect_dq("rst_abort", 2'b00, 16'h0); tick();
        drive(1, 0, 1, 0, 0, 0, 18'd3, 16'h0); expect_dq("rst_abort2", 2'b00, 16'h0); tick();
        cyc(1, 1, 1, 1, 0, 0, 18'd0, 16'h0);

        // Write with OE also low: write executes, flag depends on build.
        cyc(1, 0, 0, 0, 0, 0, 18'd1, 16'h5555);
        drive(1, 1, 1, 1, 0, 0, 18'd0, 16'h0);
        #3; chk("perr_set", 32'(perr), 32'(PCHK)); tick();
        cyc(1, 0, 1, 0, 0, 0, 18'd1, 16'h0);
        cyc(1, 0, 1, 0, 0, 0, 18'd1, 16'h0);
        drive(1, 0, 1, 0, 0, 0, 18'd1, 16'h0); expect_dq("perr_wr_data", 2'b11, 16'h5555);
        chk("perr_sticky", 32'(perr), 32'(PCHK)); tick();
        cyc(0, 1, 1, 1, 0, 0, 18'd0, 16'h0);
        drive(1, 1, 1, 1, 0, 0, 18'd0, 16'h0);
        #3; chk("perr_cleared", 32'(perr), 32'd0); tick();

        // Randomized traffic biased toward held controls and a small address pool.
        c = 0; w = 1; o = 0; u = 0; l = 0; a = pool[0];
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 40) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4, 5: begin c = 0; w = 1; o = 0; end
                    6, 7:             begin c = 0; w = 0; o = ($urandom_range(0, 9) != 0); end
                    8:                begin c = 1; w = 1'($urandom_range(0, 1)); o = 1'($urandom_range(0, 1)); end
                    default:          begin c = 0; w = 1; o = 1; end
                endcase
                u = ($urandom_range(0, 99) < 15);
                l = ($urandom_range(0, 99) < 15);
            end
            if ($urandom_range(0, 99) < 20) a = pool[$urandom_range(0, 5)];
            cyc(($urandom_range(0, 99) != 0), c, w, o, u, l, a, 16'($urandom));
        end

        cyc(1, 1, 1, 1, 0, 0, 18'd0, 16'h0);
        repeat (3) @(posedge clk);
        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/sram_responder.md
# sram_responder

Synthesizable responder for the external asynchronous-SRAM pin interface, i.e. the chip side of the bus driven by the SRAM controller in the memory stage. It decodes SRAM_CE_N/WE_N/OE_N/UB_N/LB_N and SRAM_ADDR, stores 16-bit words with byte-lane writes, and drives SRAM_DQ on reads after a programmable access latency. It serves as the on-chip memory model for simulation and FPGA builds without the physical SRAM, and as the reference responder for controller verification.

## Interface
- ADDR_W, 18, SRAM_ADDR width
- DATA_W, 16, SRAM_DQ width, two byte lanes
- DEPTH, 65536, words stored; array index = SRAM_ADDR modulo DEPTH; power of two required
- READ_LATENCY, 2, clock edges from first read-sampling edge to DQ valid; legal 1..4
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-low (asserted when 0)
- SRAM_ADDR  in  ADDR_W  word address
- SRAM_DQ  inout  DATA_W  data bus; driven only during a valid read, Z otherwise
- SRAM_CE_N, SRAM_WE_N, SRAM_OE_N  in  1 each  chip, write and output enables, active-low
- SRAM_UB_N, SRAM_LB_N  in  1 each  byte enables: UB = [15:8], LB = [7:0], active-low
- protocol_err  out  1  sticky protocol-violation flag (see Configuration)

## Operation
- Conditions, evaluated each edge:
  - write_cond = !CE_N & !WE_N
  - read_cond = !CE_N & WE_N & !OE_N
  - CE_N=1: deselected; no access occurs.
- Write: on an edge with write_cond, mem[idx][15:8] <= DQ[15:8] if !UB_N, and mem[idx][7:0] <= DQ[7:0] if !LB_N. The FSM goes to IDLE and the count clears. Combinationally, DQ is never driven while WE_N=0.
- Read FSM states: IDLE, ACCESS, VALID.
- Registers:
  - lat_addr (ADDR_W)
  - cnt (3 bits)
  - rdata (DATA_W)
- Read start: IDLE with read_cond. lat_addr <= ADDR and cnt <= 1.
  - If READ_LATENCY=1, rdata <= mem[idx] and the FSM goes to VALID.
  - Otherwise the FSM goes to ACCESS.
- ACCESS with read_cond and ADDR==lat_addr: cnt <= cnt+1. When cnt+1 == READ_LATENCY, rdata <= mem[idx] and the FSM goes to VALID.
- ACCESS or VALID with read_cond and ADDR!=lat_addr: the read restarts with the new address as from IDLE. DQ is released immediately (combinational).
- Any state with no read_cond and no write_cond: IDLE, cnt <= 0.
- DQ drive: lane driven = state==VALID & read_cond & ADDR==lat_addr & lane enable low. A disabled lane stays Z.
- Memory contents are not cleared by reset; the initial contents are undefined X in simulation.

## Timing
- Reset (rst=0 at an edge) sets:
  - state IDLE
  - cnt 0
  - lat_addr 0
  - rdata 0
  - protocol_err 0
  - DQ Z from that edge on
- Reset mid-read aborts the access. Reset mid-write blocks the write at that edge; reset has priority over all other actions.
- Read latency: DQ is valid right after the READ_LATENCY-th consecutive edge at which read_cond holds with a stable address. DQ holds until read_cond drops or the address changes.
- Write-then-read of the same address on consecutive edges returns the new data.
- A DQ release is combinational on OE_N/CE_N/WE_N/address change, so there is no bus contention against a controller turning the bus around in the same cycle.
- Address wrap: ADDR ≥ DEPTH aliases to ADDR mod DEPTH.

## Configuration
- SRAM_RESP_PROTOCOL_CHECK_EN defined: protocol_err is set at any non-reset edge with !CE_N and either of:
  - !WE_N & !OE_N (write dominates; the write still executes)
  - UB_N & LB_N while write_cond or read_cond holds
  
  protocol_err stays set until reset.
- Macro undefined: protocol_err is tied 0 and the check logic is absent. Functional behaviour is otherwise identical.

## Test plan
- Reset and idle, READ_LATENCY=2: hold rst=0 for 2 edges, then CE_N=1 -> DQ=Z, protocol_err=0; a read with no prior write returns X only.
- Full write then read: write 16'hBEEF to addr 5 with UB_N=LB_N=0, then read addr 5 -> DQ Z after the 1st read edge, 16'hBEEF after the 2nd, held while OE_N=0.
- Byte lanes: write 16'h1234 to addr 9, then write 16'hAB00 with LB_N=1 -> a read returns 16'hAB34. A read with UB_N=1 drives only [7:0]=8'h34 and leaves [15:8] Z.
- Address change mid-read: read addr 5 and at cnt=1 switch to addr 9 -> the latency counter restarts and 16'hAB34 appears 2 edges after the switch; no stale 16'hBEEF is ever driven.
- Wrap and reset abort: write 16'h0F0F to addr DEPTH+3, then read addr 3 -> 16'h0F0F. Assert rst=0 in ACCESS -> DQ stays Z and state is IDLE.
- Protocol check (macro defined): CE_N=WE_N=OE_N=0 writing 16'h5555 to addr 1 -> protocol_err=1 and stays 1, mem[1]=16'h5555. Macro undefined: same stimulus -> protocol_err=0.
